throw_sequencer: RTL and testbench
==================================

# throw_sequencer

Game-flow controller for the ball thrower. It sequences each shot through aim, flight, landing and result display, and issues the launch pulse to the ball datapath. It freezes the angle/power controls while a ball is in flight, classifies where the ball lands against the target, and keeps the running score and shot count. It sits between the switch/key inputs and the angle/power and ball blocks, and runs in the VGA clock domain, clocked by the same `clk` that drives `VGA_CLK`.

## Interface
- `GROUND_Y`, 450: first ground row; ball has landed when `ball_y >= GROUND_Y`.
- `TGT_X_MIN`, 421: leftmost target column, inclusive.
- `TGT_X_MAX`, 539: rightmost target column, inclusive.
- `CTR_X_MIN`, 436: leftmost centre column, inclusive.
- `CTR_X_MAX`, 524: rightmost centre column, inclusive.
- `SCREEN_W`, 640: `ball_x >= SCREEN_W` means the ball left the screen.
- `RESULT_FRAMES`, 120: number of frames the RESULT state is held.
- `MAX_SHOTS`, 5: number of shots per game.
- `FLIGHT_FRAMES`, 600: flight timeout in frames; used only with `SEQ_FLIGHT_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: pixel clock, the same clock as `VGA_CLK`.
- `rst` in 1: asynchronous reset, active-low.
- `update` in 1: one-cycle pulse, once per frame.
- `go` in 1: asynchronous launch switch, level input.
- `ball_x` in 10: current ball column.
- `ball_y` in 10: current ball row.
- `launch` out 1: one-cycle pulse that starts the ball.
- `aim_en` out 1: enables angle/power adjustment.
- `in_flight` out 1: high while the ball is airborne.
- `result` out 2: 0 = none, 1 = miss, 2 = target, 3 = centre.
- `score` out 8: running score.
- `shots` out 4: shots fired in the current game.
- `game_over` out 1: high once all shots are used.

## Operation
- `go` passes through a 2-FF synchroniser followed by a rising-edge detector; the result is `go_rise`.
- FSM states: AIM, FLIGHT, RESULT, OVER.
- Reset values:
  - State is AIM.
  - `launch` = 0, `aim_en` = 1, `in_flight` = 0, `result` = 0, `score` = 0, `shots` = 0, `game_over` = 0.
  - Synchroniser flops and all counters are 0.
- AIM:
  - `aim_en` = 1.
  - On `go_rise`: pulse `launch`, increment `shots`, clear `result`, go to FLIGHT.
  - `update` is ignored.
- FLIGHT:
  - `aim_en` = 0, `in_flight` = 1.
  - `go_rise` is ignored.
  - Position is evaluated only on cycles where `update` = 1, using `ball_x`/`ball_y` sampled in that cycle.
  - If `ball_x >= SCREEN_W`: `result` = 1, go to RESULT.
  - Else if `ball_y >= GROUND_Y`: classify by `ball_x`:
    - centre range → `result` = 3, `score` += 3.
    - otherwise in target range → `result` = 2, `score` += 1.
    - otherwise → `result` = 1.
    - Then go to RESULT.
- RESULT:
  - `aim_en` = 0.
  - Frame counter counts `update` pulses from 0.
  - When the count reaches `RESULT_FRAMES-1` on an `update`:
    - go to OVER if `shots == MAX_SHOTS`, else to AIM;
    - clear the counter.
- OVER:
  - `game_over` = 1, `aim_en` = 0.
  - On `go_rise`: clear `score`, `shots`, `result` and `game_over`; go to AIM. No launch is issued.
- Arithmetic:
  - `score` saturates at 255; an add that would overflow yields 255.
  - `shots` never exceeds `MAX_SHOTS`.
- Ball position already at ground when FLIGHT is entered: classified on the first `update` in FLIGHT. The ball datapath is responsible for repositioning.
- Reset asserted mid-flight: immediate return to reset values, including clearing any pending `launch`.

## Timing
- `go` rising edge to `launch` high: 3 `clk` cycles (2 sync + 1 edge/FSM register).
- `launch` is high for exactly 1 cycle, in the same cycle the state becomes FLIGHT.
- Landing `update` cycle to updated `result`, `score` and RESULT state: +1 cycle (registered).
- All outputs are registered; no combinational path from input to output.
- RESULT lasts exactly `RESULT_FRAMES` `update` pulses.
- `update` and `go_rise` in the same cycle:
  - in AIM, the launch occurs;
  - in RESULT, `go_rise` is dropped.

## Configuration
- `SEQ_FLIGHT_TIMEOUT_EN` defined:
  - A FLIGHT frame counter, cleared on entry, increments per `update`.
  - On reaching `FLIGHT_FRAMES`, the FSM forces `result` = 1 and goes to RESULT.
  - If landing and timeout fall on the same `update`, landing wins.
- Not defined: no counter is built; FLIGHT exits only on landing or leaving the screen.

## Test plan
- Reset, then `go` 0→1 → `launch` high for exactly one cycle, 3 cycles after the edge; `shots` = 1; `aim_en` = 0.
- FLIGHT with `ball_y` = 450, `ball_x` = 480 on `update` → `result` = 3, `score` = 3, RESULT held exactly 120 `update`s, then AIM.
- Landing at `ball_x` = 430 → `result` = 2, `score` +1; landing at `ball_x` = 100 → `result` = 1, score unchanged; `ball_x` = 640 in flight → `result` = 1.
- Five centre shots → `score` = 15, `shots` = 5, OVER with `game_over` = 1; next `go` edge → all cleared, AIM, no `launch`.
- `rst` low mid-FLIGHT → all outputs return to reset values asynchronously; `go` toggles during FLIGHT and RESULT → no `launch`.
- With `SEQ_FLIGHT_TIMEOUT_EN` defined, ball never lands → `result` = 1 after 600 `update`s.

Source files
------------

// File: rtl/throw_sequencer.sv
// -----------------------------------------------------------------------------
// throw_sequencer
//
// Game-flow controller for the ball thrower. Moves each shot through aim,
// flight and result display, pulses `launch` to start the ball, freezes the
// angle/power controls while a ball is in the air, classifies the landing
// point against the target and keeps the running score and shot count.
// Runs in the VGA pixel-clock domain.
//
// Ports:
//   clk        in   pixel clock (same as VGA_CLK)
//   rst        in   asynchronous reset, active-low
//   update     in   one-cycle pulse, once per frame
//   go         in   asynchronous launch switch (level)
//   ball_x     in   [9:0] current ball column
//   ball_y     in   [9:0] current ball row
//   launch     out  one-cycle pulse that starts the ball
//   aim_en     out  enables angle/power adjustment
//   in_flight  out  high while the ball is airborne
//   result     out  [1:0] 0 none, 1 miss, 2 target, 3 centre
//   score      out  [7:0] running score (saturating)
//   shots      out  [3:0] shots fired in the current game
//   game_over  out  high once all shots are used
//
// Optional feature: define SEQ_FLIGHT_TIMEOUT_EN to force a miss if the ball
// has not landed or left the screen after FLIGHT_FRAMES frames.
// -----------------------------------------------------------------------------
module throw_sequencer #(
  parameter logic [9:0]  GROUND_Y      = 10'd450,
  parameter logic [9:0]  TGT_X_MIN     = 10'd421,
  parameter logic [9:0]  TGT_X_MAX     = 10'd539,
  parameter logic [9:0]  CTR_X_MIN     = 10'd436,
  parameter logic [9:0]  CTR_X_MAX     = 10'd524,
  parameter logic [9:0]  SCREEN_W      = 10'd640,
  parameter int unsigned RESULT_FRAMES = 120,
  parameter logic [3:0]  MAX_SHOTS     = 4'd5
`ifdef SEQ_FLIGHT_TIMEOUT_EN
  ,
  parameter int unsigned FLIGHT_FRAMES = 600
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic       go,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       launch,
  output logic       aim_en,
  output logic       in_flight,
  output logic [1:0] result,
  output logic [7:0] score,
  output logic [3:0] shots,
  output logic       game_over
);

  localparam int unsigned RES_W = $clog2(RESULT_FRAMES + 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESULT_FRAMES - 1);

`ifdef SEQ_FLIGHT_TIMEOUT_EN
  localparam int unsigned FLT_W = $clog2(FLIGHT_FRAMES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FLIGHT_FRAMES - 1);
`endif

  typedef enum logic [1:0] {
    S_AIM    = 2'd0,
    S_FLIGHT = 2'd1,
    S_RESULT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             go_s1_q, go_s2_q, go_s3_q;
  logic             go_rise;
  logic             launch_q, launch_d;
  logic             aim_en_q, aim_en_d;
  logic             in_flight_q, in_flight_d;
  logic             game_over_q, game_over_d;
  logic [1:0]       result_q, result_d;
  logic [7:0]       score_q, score_d;
  logic [3:0]       shots_q, shots_d;
  logic [RES_W-1:0] res_cnt_q, res_cnt_d;
  logic [8:0]       score_sum;
  logic [1:0]       points;
  logic             on_ctr, on_tgt;

`ifdef SEQ_FLIGHT_TIMEOUT_EN
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
`endif

  // Two synchroniser stages, then a third flop holding the previous
  // synchronised level for edge detection.
  assign go_rise = go_s2_q & ~go_s3_q;

  assign on_ctr = (ball_x >= CTR_X_MIN) && (ball_x <= CTR_X_MAX);
  assign on_tgt = (ball_x >= TGT_X_MIN) && (ball_x <= TGT_X_MAX);

  always_comb begin
    state_d   = state_q;
    launch_d  = 1'b0;
    result_d  = result_q;
    score_d   = score_q;
    shots_d   = shots_q;
    res_cnt_d = res_cnt_q;
    points    = 2'd0;
    score_sum = 9'd0;
`ifdef SEQ_FLIGHT_TIMEOUT_EN
    flt_cnt_d = flt_cnt_q;
`endif

    case (state_q)
      S_AIM: begin
        if (go_rise) begin
          launch_d = 1'b1;
          if (shots_q < MAX_SHOTS) shots_d = shots_q + 4'd1;
          result_d = 2'd0;
          state_d  = S_FLIGHT;
`ifdef SEQ_FLIGHT_TIMEOUT_EN
          flt_cnt_d = '0;
`endif
        end
      end

      S_FLIGHT: begin
        if (update) begin
          if (ball_x >= SCREEN_W) begin
            result_d  = 2'd1;
            state_d   = S_RESULT;
            res_cnt_d = '0;
          end else if (ball_y >= GROUND_Y) begin
            if (on_ctr) begin
              result_d = 2'd3;
              points   = 2'd3;
            end else if (on_tgt) begin
              result_d = 2'd2;
              points   = 2'd1;
            end else begin
              result_d = 2'd1;
            end
            // 9-bit sum so the carry flags a saturating overflow
            score_sum = {1'b0, score_q} + {7'd0, points};
            score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
            state_d   = S_RESULT;
            res_cnt_d = '0;
`ifdef SEQ_FLIGHT_TIMEOUT_EN
          end else if (flt_cnt_q == FLT_LAST) begin
            // landing/off-screen are checked first, so they win a tie
            result_d  = 2'd1;
            state_d   = S_RESULT;
            res_cnt_d = '0;
          end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
`endif
          end
        end
      end

      S_RESULT: begin
        if (update) begin
          if (res_cnt_q == RES_LAST) begin
            res_cnt_d = '0;
            state_d   = (shots_q == MAX_SHOTS) ? S_OVER : S_AIM;
          end else begin
            res_cnt_d = res_cnt_q + 1'b1;
          end
        end
      end

      S_OVER: begin
        if (go_rise) begin
          score_d  = '0;
          shots_d  = '0;
          result_d = 2'd0;
          state_d  = S_AIM;
        end
      end

      default: state_d = S_AIM;
    endcase

    // Status outputs follow the next state so they are registered
    // alongside it.
    aim_en_d    = (state_d == S_AIM);
    in_flight_d = (state_d == S_FLIGHT);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_AIM;
      go_s1_q     <= 1'b0;
      go_s2_q     <= 1'b0;
      go_s3_q     <= 1'b0;
      launch_q    <= 1'b0;
      aim_en_q    <= 1'b1;
      in_flight_q <= 1'b0;
      game_over_q <= 1'b0;
      result_q    <= 2'd0;
      score_q     <= '0;
      shots_q     <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      go_s1_q     <= go;
      go_s2_q     <= go_s1_q;
      go_s3_q     <= go_s2_q;
      launch_q    <= launch_d;
      aim_en_q    <= aim_en_d;
      in_flight_q <= in_flight_d;
      game_over_q <= game_over_d;
      result_q    <= result_d;
      score_q     <= score_d;
      shots_q     <= shots_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

`ifdef SEQ_FLIGHT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flt_cnt_q <= '0;
    else      flt_cnt_q <= flt_cnt_d;
  end
`endif

  assign launch    = launch_q;
  assign aim_en    = aim_en_q;
  assign in_flight = in_flight_q;
  assign result    = result_q;
  assign score     = score_q;
  assign shots     = shots_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_throw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_throw_sequencer
//
// Directed bench for throw_sequencer: reset values, launch latency, landing
// classification and target/centre boundaries, result hold length, game-over
// and restart, asynchronous reset mid-flight, and flight timeout (the
// expectation depends on SEQ_FLIGHT_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_throw_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       update;
  logic       go;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       launch;
  logic       aim_en;
  logic       in_flight;
  logic [1:0] result;
  logic [7:0] score;
  logic [3:0] shots;
  logic       game_over;

  int vectors     = 0;
  int miscompares = 0;
  int launch_cnt  = 0;

  int g2_x[5]   = '{480, 524, 436, 500, 440};
  int g3_x[5]   = '{421, 539, 420, 540, 525};
  int g3_res[5] = '{2, 2, 1, 1, 2};
  int g3_scr[5] = '{1, 2, 2, 2, 3};

  throw_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .update    (update),
    .go        (go),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .launch    (launch),
    .aim_en    (aim_en),
    .in_flight (in_flight),
    .result    (result),
    .score     (score),
    .shots     (shots),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (launch === 1'b1) launch_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
  endtask

  task automatic go_edge();
    go = 1'b0;
    repeat (3) tick();
    go = 1'b1;
    repeat (3) tick();
  endtask

  task automatic fire(input int exp_shots);
    go_edge();
    chk("fire_launch", 32'(launch), 1);
    chk("fire_shots", 32'(shots), 32'(exp_shots));
    chk("fire_aim_en", 32'(aim_en), 0);
    chk("fire_in_flight", 32'(in_flight), 1);
    chk("fire_result_clr", 32'(result), 0);
    tick();
    chk("fire_launch_1cyc", 32'(launch), 0);
  endtask

  task automatic land(input int x, input int y, input int exp_res, input int exp_score);
    ball_x = 10'(x);
    ball_y = 10'(y);
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("land_result", 32'(result), 32'(exp_res));
    chk("land_score", 32'(score), 32'(exp_score));
    chk("land_in_flight", 32'(in_flight), 0);
    ball_x = 10'd0;
    ball_y = 10'd0;
  endtask

  task automatic finish_result(input logic exp_over);
    repeat (119) pulse_update();
    chk("res_hold_aim_en", 32'(aim_en), 0);
    chk("res_hold_over", 32'(game_over), 0);
    pulse_update();
    chk("res_exit_aim_en", 32'(aim_en), 32'(!exp_over));
    chk("res_exit_over", 32'(game_over), 32'(exp_over));
  endtask

  initial begin
    rst    = 1'b0;
    update = 1'b0;
    go     = 1'b0;
    ball_x = 10'd0;
    ball_y = 10'd0;
    repeat (3) tick();
    chk("rst_launch", 32'(launch), 0);
    chk("rst_aim_en", 32'(aim_en), 1);
    chk("rst_in_flight", 32'(in_flight), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_shots", 32'(shots), 0);
    chk("rst_game_over", 32'(game_over), 0);
    rst = 1'b1;
    repeat (2) tick();

    // ---- game 1, shot 1: launch latency and centre landing
    go = 1'b1;
    tick();
    chk("lat_c1", 32'(launch), 0);
    tick();
    chk("lat_c2", 32'(launch), 0);
    tick();
    chk("lat_c3", 32'(launch), 1);
    chk("lat_shots", 32'(shots), 1);
    chk("lat_aim_en", 32'(aim_en), 0);
    tick();
    chk("lat_1cyc", 32'(launch), 0);
    // ground position without update must not be evaluated
    ball_x = 10'd480;
    ball_y = 10'd450;
    repeat (2) tick();
    chk("no_update_flight", 32'(in_flight), 1);
    land(480, 450, 3, 3);
    // go edge during RESULT is dropped
    go_edge();
    chk("res_go_launches", 32'(launch_cnt), 1);
    chk("res_go_shots", 32'(shots), 1);
    finish_result(1'b0);

    // ---- shot 2: go toggled in flight, target landing
    fire(2);
    go_edge();
    chk("flt_go_launches", 32'(launch_cnt), 2);
    chk("flt_go_in_flight", 32'(in_flight), 1);
    land(430, 450, 2, 4);
    finish_result(1'b0);

    // ---- shot 3: ground miss
    fire(3);
    land(100, 450, 1, 4);
    finish_result(1'b0);

    // ---- shot 4: just inside screen above ground, then off screen
    fire(4);
    ball_x = 10'd639;
    ball_y = 10'd449;
    pulse_update();
    chk("edge_639_449", 32'(in_flight), 1);
    land(640, 200, 1, 4);
    finish_result(1'b0);

    // ---- shot 5: centre left edge, ends the game
    fire(5);
    land(436, 450, 3, 7);
    finish_result(1'b1);
    chk("g1_shots", 32'(shots), 5);
    chk("g1_score", 32'(score), 7);

    go_edge();
    chk("rs1_over", 32'(game_over), 0);
    chk("rs1_score", 32'(score), 0);
    chk("rs1_shots", 32'(shots), 0);
    chk("rs1_result", 32'(result), 0);
    chk("rs1_aim_en", 32'(aim_en), 1);
    chk("rs1_no_launch", 32'(launch_cnt), 5);

    // ---- game 2: five centre shots
    for (int i = 0; i < 5; i++) begin
      fire(i + 1);
      land(g2_x[i], 460, 3, 3 * (i + 1));
      finish_result(i == 4);
    end
    chk("g2_score", 32'(score), 15);
    chk("g2_shots", 32'(shots), 5);
    chk("g2_over", 32'(game_over), 1);
    go_edge();
    chk("rs2_score", 32'(score), 0);
    chk("rs2_no_launch", 32'(launch_cnt), 10);

    // ---- game 3: target / centre boundaries
    for (int i = 0; i < 5; i++) begin
      fire(i + 1);
      land(g3_x[i], 450, g3_res[i], g3_scr[i]);
      finish_result(i == 4);
    end
    go_edge();
    chk("rs3_shots", 32'(shots), 0);

    // ---- asynchronous reset while launch is high
    go_edge();
    chk("ar_launch_pre", 32'(launch), 1);
    go = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("ar_launch", 32'(launch), 0);
    chk("ar_in_flight", 32'(in_flight), 0);
    chk("ar_aim_en", 32'(aim_en), 1);
    chk("ar_shots", 32'(shots), 0);
    chk("ar_result", 32'(result), 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("ar_stays_aim", 32'(aim_en), 1);

    // ---- flight that never lands
    fire(1);
    ball_x = 10'd300;
    ball_y = 10'd100;
    repeat (599) pulse_update();
    chk("to_599_in_flight", 32'(in_flight), 1);
    pulse_update();
`ifdef SEQ_FLIGHT_TIMEOUT_EN
    chk("to_600_result", 32'(result), 1);
    chk("to_600_in_flight", 32'(in_flight), 0);
`else
    chk("to_600_result", 32'(result), 0);
    chk("to_600_in_flight", 32'(in_flight), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
